neuron_sequencer: RTL and testbench

- Controller that sequences one neuron's multiply-accumulate over NUM_WEIGHTS inputs: drives the weight-memory read address, selects the matching input word, accumulates products, adds the bias and presents a saturated 32-bit result.
- Sits between the layer controller (start/done) and a per-neuron weight memory (combinational read: weight_value valid in the same cycle as read_address).
- Arithmetic is signed fixed point Q(DATA_W-FRAC_W).FRAC_W.

---
 rtl/neuron_pkg.sv | 23 ++
 rtl/fxp_mac.sv | 49 ++++
 rtl/neuron_sequencer.sv | 126 ++++++++++++
 tb/tb_neuron_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and fixed-point constants for the neuron datapath blocks.
package neuron_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_BIAS = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int FRAC_W_DEF = 16;

  localparam logic [DATA_W_DEF-1:0] ONE     = DATA_W_DEF'(1) << FRAC_W_DEF;
  localparam logic [DATA_W_DEF-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W_DEF-1:0] SAT_MIN = 32'h8000_0000;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// Combinational fixed-point MAC term (signed multiply, >>> FRAC_W, sign-extend)
// plus saturation of a wide accumulator back to DATA_W.
module fxp_mac
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = 64
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [ACC_W-1:0]  term_o,
  output logic        [DATA_W-1:0] sat_o
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_sh;

  assign prod    = a_i * b_i;
  assign prod_sh = prod >>> FRAC_W;

  generate
    if (ACC_W > PROD_W) begin : g_ext
      assign term_o = {{(ACC_W-PROD_W){prod_sh[PROD_W-1]}}, prod_sh};
    end else if (ACC_W == PROD_W) begin : g_eq
      assign term_o = prod_sh;
    end else begin : g_trunc
      // Upper bits past ACC_W are sign copies when the sizing rule holds.
      assign term_o = prod_sh[ACC_W-1:0];
    end
  endgenerate

  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > ACC_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < ACC_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return v[DATA_W-1:0];
  endfunction

  assign sat_o = saturate(acc_i);

endmodule

// File: rtl/neuron_sequencer.sv
// Sequences one neuron's MAC over NUM_WEIGHTS terms, adds bias, saturates.
// Optional ReLU on the output when NEURON_SEQ_RELU_EN is defined.
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter int NUM_WEIGHTS = 784,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAC_W      = FRAC_W_DEF,
  parameter int ACC_W       = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_WEIGHTS*DATA_W-1:0] inputs,
  input  logic [DATA_W-1:0]             bias_value,
  input  logic [DATA_W-1:0]             weight_value,
  output logic [31:0]                   read_address,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_W-1:0]             result
);

  localparam int          AW   = idx_w(NUM_WEIGHTS);
  localparam logic [31:0] LAST = 32'(NUM_WEIGHTS - 1);

  state_e                    state_q, state_d;
  logic [31:0]               addr_q, addr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [DATA_W-1:0]         result_q, result_d;

  logic [DATA_W-1:0]         in_words [NUM_WEIGHTS];
  logic [DATA_W-1:0]         in_word;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   bias_ext;
  logic [DATA_W-1:0]         sat;
  logic [DATA_W-1:0]         out_val;

  for (genvar g = 0; g < NUM_WEIGHTS; g++) begin : g_words
    assign in_words[g] = inputs[g*DATA_W +: DATA_W];
  end

  assign in_word  = in_words[addr_q[AW-1:0]];
  assign bias_ext = {{(ACC_W-DATA_W){bias_value[DATA_W-1]}}, bias_value};

  fxp_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_i    (in_word),
    .b_i    (weight_value),
    .acc_i  (acc_q),
    .term_o (term),
    .sat_o  (sat)
  );

`ifdef NEURON_SEQ_RELU_EN
  assign out_val = sat[DATA_W-1] ? '0 : sat;
`else
  assign out_val = sat;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + term;
        if (addr_q == LAST) state_d = S_BIAS;
        else                addr_d  = addr_q + 32'd1;
      end
      S_BIAS: begin
        acc_d   = acc_q + bias_ext;
        addr_d  = '0;
        state_d = S_OUT;
      end
      S_OUT: begin
        // start is not looked at here, so a request landing on this edge is dropped.
        result_d = out_val;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        addr_d   = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign read_address = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer: 4-weight and 1-weight instances.
module tb_neuron_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start4 = 1'b0, start1 = 1'b0;
  logic [127:0] in4 = '0;
  logic [31:0]  in1 = '0;
  logic [31:0]  bias4 = '0, bias1 = '0;
  logic [31:0]  wv4, wv1;
  logic [31:0]  w4 [4];
  logic [31:0]  w1 = '0;
  logic [31:0]  ra4, ra1, res4, res1;
  logic         busy4, busy1, done4, done1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign wv4 = (ra4 < 32'd4) ? w4[ra4[1:0]] : 32'hDEAD_BEEF;
  assign wv1 = (ra1 == 32'd0) ? w1 : 32'hDEAD_BEEF;

  neuron_sequencer #(.NUM_WEIGHTS(4), .DATA_W(32), .FRAC_W(16), .ACC_W(64)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .inputs(in4), .bias_value(bias4),
    .weight_value(wv4), .read_address(ra4), .busy(busy4), .done(done4), .result(res4));

  neuron_sequencer #(.NUM_WEIGHTS(1), .DATA_W(32), .FRAC_W(16), .ACC_W(64)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .inputs(in1), .bias_value(bias1),
    .weight_value(wv1), .read_address(ra1), .busy(busy1), .done(done1), .result(res1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [31:0] i0, i1, i2, i3, x0, x1, x2, x3, b);
    in4 = {i3, i2, i1, i0};
    w4[0] = x0; w4[1] = x1; w4[2] = x2; w4[3] = x3;
    bias4 = b;
  endtask

  task automatic pulse4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic wait_done4(output int cyc);
    cyc = 0;
    while (!done4 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_tests++; if (ra4 !== 32'd0)  begin n_fail++; $display("FAIL reset_addr4: got %h expected %h", ra4, 32'd0); end
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
    n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4: got %b expected 0", done4); end
    n_tests++; if (res4 !== 32'd0) begin n_fail++; $display("FAIL reset_result4: got %h expected %h", res4, 32'd0); end
    n_tests++; if (res1 !== 32'd0) begin n_fail++; $display("FAIL reset_result1: got %h expected %h", res1, 32'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] ea [5];
    ea = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd0};
    load4(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
          32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000);
    pulse4();
    n_tests++; if (ra4 !== 32'd0)  begin n_fail++; $display("FAIL basic_addr_e0: got %h expected 0", ra4); end
    n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_e0: got %b expected 1", busy4); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++; if (ra4 !== ea[k]) begin n_fail++; $display("FAIL basic_addr_e%0d: got %h expected %h", k+1, ra4, ea[k]); end
      n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL basic_early_done_e%0d: got %b expected 0", k+1, done4); end
    end
    tick();
    n_tests++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL basic_done_e6: got %b expected 1", done4); end
    n_tests++; if (res4 !== 32'h0002_4000) begin n_fail++; $display("FAIL basic_result: got %h expected %h", res4, 32'h0002_4000); end
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_e6: got %b expected 0", busy4); end
    n_tests++; if (ra4 !== 32'd0)  begin n_fail++; $display("FAIL basic_addr_e6: got %h expected 0", ra4); end
    tick();
    n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done4); end
    n_tests++; if (res4 !== 32'h0002_4000) begin n_fail++; $display("FAIL basic_hold: got %h expected %h", res4, 32'h0002_4000); end
  endtask

  task automatic test_signed_mix();
    int cyc;
    logic [31:0] exp_r;
`ifdef NEURON_SEQ_RELU_EN
    exp_r = 32'h0000_0000;
`else
    exp_r = 32'hFFFB_0000;
`endif
    load4(32'h0001_0000, 32'hFFFE_0000, 32'h0003_0000, 32'hFFFF_8000,
          32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0004_0000, 32'h0000_0000);
    pulse4();
    wait_done4(cyc);
    n_tests++; if (cyc != 6)      begin n_fail++; $display("FAIL mix_latency: got %0d expected 6", cyc); end
    n_tests++; if (res4 !== exp_r) begin n_fail++; $display("FAIL mix_result: got %h expected %h", res4, exp_r); end
    tick();
  endtask

  task automatic test_saturation();
    int cyc;
    logic [31:0] exp_neg;
`ifdef NEURON_SEQ_RELU_EN
    exp_neg = 32'h0000_0000;
`else
    exp_neg = 32'h8000_0000;
`endif
    load4(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000,
          32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF);
    pulse4();
    wait_done4(cyc);
    n_tests++; if (res4 !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_pos: got %h expected %h", res4, 32'h7FFF_FFFF); end
    tick();
    load4(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000,
          32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h0000_0000);
    pulse4();
    wait_done4(cyc);
    n_tests++; if (res4 !== exp_neg) begin n_fail++; $display("FAIL sat_neg: got %h expected %h", res4, exp_neg); end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ndone = 0;
    load4(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
          32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000);
    pulse4();                                 // accepted at e0
    tick(); if (done4) ndone++;               // e1
    start4 = 1'b1;
    tick(); if (done4) ndone++;               // e2: ignored
    start4 = 1'b0;
    n_tests++; if (ra4 !== 32'd2)  begin n_fail++; $display("FAIL b2b_addr_e2: got %h expected 2", ra4); end
    n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_e2: got %b expected 1", busy4); end
    for (int k = 3; k < 6; k++) begin tick(); if (done4) ndone++; end
    start4 = 1'b1;
    tick(); if (done4) ndone++;               // e6: done edge, request dropped
    n_tests++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL b2b_done_e6: got %b expected 1", done4); end
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_e6: got %b expected 0", busy4); end
    n_tests++; if (ndone != 1)     begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", ndone); end
    tick();                                   // e7: accepted
    start4 = 1'b0;
    n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b expected 1", busy4); end
    n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL b2b_restart_done: got %b expected 0", done4); end
    wait_done4(cyc);
    n_tests++; if (cyc != 6) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 6", cyc); end
    n_tests++; if (res4 !== 32'h0002_4000) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", res4, 32'h0002_4000); end
    tick();
  endtask

  task automatic test_reset_midop();
    int cyc;
    int ndone = 0;
    load4(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
          32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000);
    pulse4();
    tick(); tick();
    n_tests++; if (ra4 !== 32'd2) begin n_fail++; $display("FAIL midrst_pre_addr: got %h expected 2", ra4); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ra4 !== 32'd0)  begin n_fail++; $display("FAIL midrst_addr: got %h expected 0", ra4); end
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy4); end
    n_tests++; if (res4 !== 32'd0) begin n_fail++; $display("FAIL midrst_result: got %h expected 0", res4); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin tick(); if (done4) ndone++; end
    n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
    pulse4();
    wait_done4(cyc);
    n_tests++; if (res4 !== 32'h0002_4000) begin n_fail++; $display("FAIL midrst_rerun: got %h expected %h", res4, 32'h0002_4000); end
    tick();
  endtask

  task automatic test_edge_size();
    int cyc;
    logic [31:0] exp_r;
`ifdef NEURON_SEQ_RELU_EN
    exp_r = 32'h0000_0000;
`else
    exp_r = 32'hFFFF_C000;
`endif
    in1 = 32'h0003_0000; w1 = 32'h0000_4000; bias1 = 32'hFFFF_0000;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL nw1_busy: got %b expected 1", busy1); end
    cyc = 0;
    while (!done1 && cyc < 20) begin tick(); cyc++; end
    n_tests++; if (cyc != 3)       begin n_fail++; $display("FAIL nw1_latency: got %0d expected 3", cyc); end
    n_tests++; if (res1 !== exp_r) begin n_fail++; $display("FAIL nw1_result: got %h expected %h", res1, exp_r); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed_mix();
    test_saturation();
    test_back_to_back();
    test_reset_midop();
    test_edge_size();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
